// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a show-ahead byte FIFO in its read clock domain.
// Each popped byte goes out as start, 8 data bits LSB-first, optional even parity, then stop bit(s).
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       rd_clk,
  input  logic       reset_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    fifo_rd    = 1'b0;
    frame_done = 1'b0;

    if (state_q != S_IDLE && state_q != S_ARM) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_en && !fifo_empty) state_d = S_ARM;
      end
      // Second consecutive non-empty sample: data_out is now valid, so latch and pop together.
      S_ARM: begin
        if (fifo_empty) begin
          state_d = S_IDLE;
        end else begin
          shift_d = fifo_data;
          par_d   = ^fifo_data;
          fifo_rd = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      // idx_q counts stop bits here so the two-stop-bit case needs no extra counter.
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            frame_done = 1'b1;
            idx_d      = '0;
            state_d    = S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The pin level is decoded from the next state so the registered tx lines up with state_q.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the 8-entry dual-clock byte FIFO; runs entirely in the FIFO's read clock domain.
- Pops bytes from the FIFO and serialises each as an asynchronous UART frame: start bit, 8 data bits LSB-first, optional even parity, 1 or 2 stop bits.
- Drives the FIFO's rd strobe directly and samples its registered data_out/empty outputs. Feeds the board-level serial TX pin.

Parameters:
- CLKS_PER_BIT, 16, rd_clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0, 1 inserts an even-parity bit after data bit 7.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- rd_clk  input  1  block clock; same clock as the FIFO read side.
- reset_n  input  1  asynchronous active-low reset.
- tx_en  input  1  when high, allows a new frame to start. Sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO data_out; show-ahead head-of-queue byte.
- fifo_rd  output  1  one-cycle pop strobe to the FIFO rd input.
- tx  output  1  serial line; idle high.
- busy  output  1  high from ARM entry until the last stop bit completes.
- frame_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, baud counter=0, bit index=0, shift register=0, parity=0.
- FIFO interface rule: fifo_data is trusted only after fifo_empty has been sampled low on two consecutive rd_clk edges. This covers the FIFO's registered data_out lag.
- fifo_rd is only ever asserted for exactly one cycle, and only while fifo_empty=0. The block never pops an empty FIFO.
- States and transitions:
  - IDLE: tx=1. If tx_en=1 and fifo_empty=0, go to ARM.
  - ARM (1 cycle): if fifo_empty=1, return to IDLE (glitch abort, no pop). Otherwise latch fifo_data into the shift register, compute parity = XOR of the byte, assert fifo_rd, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles. Then shift right and increment the index. After bit 7, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done pulses in the final cycle. Then go to IDLE.
- Throughput: back-to-back frames with the FIFO non-empty and tx_en=1 have exactly 2 idle-high cycles between the end of stop and the start bit (IDLE + ARM).
- Latency: the start bit begins on the 2nd rd_clk edge after the first edge that sees fifo_empty=0 with tx_en=1.
- Baud counter: counts 0..CLKS_PER_BIT-1, width ceil(log2(CLKS_PER_BIT)). Reloads to 0 on every bit boundary.
- tx is registered, so there are no combinational glitches on the pin.
- tx_en deassertion mid-frame has no effect. The current frame completes and the next frame is inhibited.
- fifo_empty changes after ARM are ignored for the rest of the frame.
- reset_n assertion mid-frame: immediately forces tx=1 and IDLE. The byte already popped is lost, by design.
- Frame length in cycles = CLKS_PER_BIT*(10+PARITY_EN+STOP_BITS-1).

Test Plan:
- CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1; FIFO holds 0xA5, tx_en=1 → exactly one fifo_rd pulse. tx = 0 (4 cyc), then 1,0,1,0,0,1,0,1 (4 cyc each), then 1 (4 cyc). frame_done on cycle 40 of the frame.
- Three bytes 0x00, 0xFF, 0x3C queued → three frames; each gap between stop end and next start bit is exactly 2 cycles. Three fifo_rd pulses total, and fifo_empty rises after the third.
- PARITY_EN=1, STOP_BITS=2, byte 0x07 → parity bit=1, then tx high for 8 cycles. Frame length is 48 cycles.
- FIFO empty, tx_en=1 for 100 cycles → fifo_rd never asserts, tx stays 1, busy stays 0. A one-cycle fifo_empty low glitch produces an ARM abort with no pop.
- tx_en=0 with a non-empty FIFO → no frame. Deassert tx_en mid-data-bit 3 → the frame finishes and no further pop occurs.
- Assert reset_n low during data bit 5 → tx=1 and busy=0 asynchronously. After release, the block stays idle until the next non-empty FIFO is seen.
